commit_trace_ctrl: RTL and testbench
====================================

# commit_trace_ctrl

Sequencer between the core's writeback/commit stage and the instruction-info DPI trace port. Buffers retired-instruction events (instruction word, dynamic next PC) in a small FIFO. Presents them one per cycle to the trace sink under simulator throttle, and counts retirements. Detects the `ebreak` halt instruction and a commit-stall watchdog timeout, then drives the simulation end-of-run handshake.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT_CYCLES, 1024, consecutive non-accept cycles in RUN before timeout; ≥2
- EBREAK_INST, 32'h00100073, encoding that triggers halt

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- in_valid  input  1  commit stage presents a retired instruction
- in_ready  output  1  controller accepts; accept = in_valid & in_ready
- in_inst  input  32  retired instruction word
- in_dnpc  input  64  next PC after that instruction
- trace_en  input  1  sink may consume this cycle (simulator throttle)
- out_valid  output  1  trace entry presented; consumed when out_valid & trace_en
- out_inst  output  32  head-entry instruction
- out_dnpc  output  64  head-entry next PC
- retired_count  output  64  number of entries consumed by the sink
- halt  output  1  ebreak retired and fully drained
- timeout  output  1  watchdog expired
- busy  output  1  FIFO non-empty

## Operation
- FSM states: RUN, DRAIN, HALT, STUCK; reset state RUN.
- Transitions:
  - RUN -> DRAIN on accept with in_inst == EBREAK_INST.
  - RUN -> STUCK when watchdog expires (rule below).
  - DRAIN -> HALT when FIFO empty.
  - HALT and STUCK are sticky until reset.
  - Ebreak accept and watchdog expiry in the same cycle cannot occur, since an accept clears the watchdog.
- FIFO:
  - DEPTH entries of {inst, dnpc}; read/write pointers of log2(DEPTH) bits wrap modulo DEPTH.
  - Occupancy count has log2(DEPTH)+1 bits.
  - Push on accept; pop on out_valid & trace_en.
  - Simultaneous push and pop leaves occupancy unchanged and is legal at any occupancy except empty. There is no bypass, so pop needs a stored entry.
- in_ready = (state == RUN) & (occupancy < DEPTH). A full FIFO deasserts in_ready even if a pop occurs in the same cycle.
- The ebreak entry itself is pushed and traced like any other entry.
- out_valid = occupancy != 0, independent of trace_en. out_inst/out_dnpc show the head entry; their value is don't-care when out_valid=0.
- Draining continues in every state: RUN, DRAIN and STUCK.
- retired_count increments by 1 per pop and wraps at 2^64.
- Watchdog:
  - Counter is cleared on accept and on any cycle not in RUN.
  - Otherwise it increments, saturating at TIMEOUT_CYCLES-1.
  - Expiry condition: state RUN, counter == TIMEOUT_CYCLES-1, no accept this cycle.
- Outputs:
  - halt = (state == HALT)
  - timeout = (state == STUCK)
  - busy = occupancy != 0
- Reset values: FIFO empty, pointers 0, retired_count 0, watchdog 0, state RUN.
  - Resulting outputs: in_ready=1, out_valid=0, halt=0, timeout=0, busy=0.
  - Reset mid-operation discards all buffered entries without presenting them.

## Timing
- All outputs derive combinationally from registered state only; there is no path from in_* to out_* or to in_ready.
- Push latency: an entry accepted at edge t has out_valid=1 in cycle t+1 at the earliest.
- Throughput: 1 accept and 1 pop per cycle sustained.
- halt rises the cycle after the edge on which the last entry (the ebreak) is popped.
- Ebreak accepted into an empty FIFO with trace_en=1: halt is asserted 2 cycles after the accept edge.
- timeout rises the cycle after the expiry edge: TIMEOUT_CYCLES idle RUN cycles (counted from cycle 0) give timeout=1 in cycle TIMEOUT_CYCLES.

## Test plan
- Basic trace:
  - Stimulus: push inst 0x00000013 with dnpc 0x80000004, trace_en=1.
  - Required: next cycle out_valid=1, out_inst=0x00000013, out_dnpc=0x80000004; following cycle retired_count=1, busy=0.
- Backpressure (DEPTH=4):
  - Stimulus: trace_en=0, push 5 back-to-back.
  - Required: in_ready=0 after 4th accept and the 5th is held.
  - Then set trace_en=1: entries emerge in order, and the 5th is accepted the cycle after occupancy drops to 3.
- Wrap-around:
  - Stimulus: 10 pushes with continuous trace_en=1 and sequential dnpc values.
  - Required: in-order output, no loss; retired_count=10.
- Halt:
  - Stimulus: push 2 entries, then 0x00100073, with trace_en=0.
  - Required: in_ready=0 immediately after the ebreak accept.
  - Then raise trace_en: 3 pops, then halt=1 and retired_count=3; further in_valid is ignored.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: no in_valid after reset.
  - Required: timeout=0 through cycle 15, timeout=1 from cycle 16, in_ready=0 from then on.
  - A single accept at cycle 10 restarts the count.
- Reset mid-drain:
  - Stimulus: 3 entries buffered, trace_en=0, then reset=0 for one edge.
  - Required: busy=0, out_valid=0, retired_count=0, in_ready=1.

Source files
------------

// File: rtl/commit_trace_if.sv
// Bundle of the commit-side and trace-side signals of commit_trace_ctrl.
//   slave  : the controller (takes commit events and trace_en, drives the trace side)
//   master : the environment (commit stage plus trace sink)
// Signals: in_valid/in_ready/in_inst/in_dnpc form the commit handshake.
//          trace_en/out_valid/out_inst/out_dnpc form the trace port.
//          retired_count/halt/timeout/busy are status outputs.
interface commit_trace_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_dnpc;
  logic        trace_en;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_dnpc;
  logic [63:0] retired_count;
  logic        halt;
  logic        timeout;
  logic        busy;

  modport slave (
    input  in_valid, in_inst, in_dnpc, trace_en,
    output in_ready, out_valid, out_inst, out_dnpc, retired_count, halt, timeout, busy
  );

  modport master (
    output in_valid, in_inst, in_dnpc, trace_en,
    input  in_ready, out_valid, out_inst, out_dnpc, retired_count, halt, timeout, busy
  );
endinterface

// File: rtl/commit_trace_ctrl.sv
// Sequencer between the commit stage and the instruction trace sink.
// Retired {inst, dnpc} events are buffered in a DEPTH-entry FIFO and handed
// to the sink one per cycle when trace_en allows. Retirements are counted.
// An accepted ebreak stops intake and, once the FIFO drains, raises halt.
// A watchdog raises timeout after TIMEOUT_CYCLES cycles in RUN without an accept.
// Ports:
//   clock : rising-edge clock for all state
//   reset : synchronous, active-low
//   bus   : commit_trace_if.slave with the commit handshake, trace port and status
module commit_trace_ctrl #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] EBREAK_INST    = 32'h0010_0073
) (
  input logic            clock,
  input logic            reset,
  commit_trace_if.slave  bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned WdW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Full  = CntW'(DEPTH);
  localparam logic [WdW-1:0]  WdMax = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StRun, StDrain, StHalt, StStuck} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [63:0]     retired_q, retired_d;
  logic [WdW-1:0]  wd_q, wd_d;

  // Payload storage is not reset; occupancy alone decides what is valid.
  logic [31:0] inst_mem [DEPTH];
  logic [63:0] dnpc_mem [DEPTH];

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  // Everything visible outside depends on registered state only.
  always_comb begin
    in_ready  = (state_q == StRun) && (occ_q < Full);
    out_valid = (occ_q != '0);
    push      = bus.in_valid && in_ready;
    pop       = out_valid && bus.trace_en;
  end

  always_comb begin
    bus.in_ready      = in_ready;
    bus.out_valid     = out_valid;
    bus.out_inst      = inst_mem[rd_ptr_q];
    bus.out_dnpc      = dnpc_mem[rd_ptr_q];
    bus.retired_count = retired_q;
    bus.halt          = (state_q == StHalt);
    bus.timeout       = (state_q == StStuck);
    bus.busy          = out_valid;
  end

  // FIFO bookkeeping, retirement counter and watchdog.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    retired_d = pop  ? retired_q + 64'd1   : retired_q;
    occ_d     = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase

    wd_d = wd_q;
    if (push || (state_q != StRun)) begin
      wd_d = '0;
    end else if (wd_q != WdMax) begin
      wd_d = wd_q + WdW'(1);
    end
  end

  // Next state. DRAIN looks at the post-edge occupancy so halt is visible the
  // cycle right after the ebreak entry is popped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun: begin
        if (push && (bus.in_inst == EBREAK_INST)) begin
          state_d = StDrain;
        end else if (!push && (wd_q == WdMax)) begin
          state_d = StStuck;
        end
      end
      StDrain: begin
        if (occ_d == '0) state_d = StHalt;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StRun;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      retired_q <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      retired_q <= retired_d;
      wd_q      <= wd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.in_inst;
      dnpc_mem[wr_ptr_q] <= bus.in_dnpc;
    end
  end

endmodule

// File: tb/tb_commit_trace_ctrl.sv
// Directed bench for commit_trace_ctrl (DEPTH=4, TIMEOUT_CYCLES=16).
// A vector table covers the basic trace and backpressure; short hand-written
// sequences cover wrap-around, halt, timeout and reset mid-drain.
module tb_commit_trace_ctrl;

  localparam logic [31:0] Ebreak = 32'h0010_0073;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  commit_trace_if bus ();

  commit_trace_ctrl #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16),
    .EBREAK_INST    (Ebreak)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [31:0] inst;
    logic [63:0] dnpc;
    logic        ten;
    logic        rdy;
    logic        ov;
    logic [31:0] oinst;
    logic [63:0] odnpc;
    logic [63:0] cnt;
    logic        busy;
    logic        halt;
    logic        tmo;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic vld, logic [31:0] inst, logic [63:0] dnpc, logic ten,
                              logic rdy, logic ov, logic [31:0] oinst, logic [63:0] odnpc,
                              logic [63:0] cnt, logic busy);
    vec_t v;
    v.vld = vld;   v.inst = inst;   v.dnpc = dnpc;   v.ten = ten;
    v.rdy = rdy;   v.ov = ov;       v.oinst = oinst; v.odnpc = odnpc;
    v.cnt = cnt;   v.busy = busy;   v.halt = 1'b0;   v.tmo = 1'b0;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] inst, input logic [63:0] dnpc,
                       input logic ten);
    bus.in_valid = vld;
    bus.in_inst  = inst;
    bus.in_dnpc  = dnpc;
    bus.trace_en = ten;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic ov,
                              input logic [63:0] cnt, input logic busy, input logic halt,
                              input logic tmo);
    check({tag, ".in_ready"},      {63'd0, bus.in_ready},  {63'd0, rdy});
    check({tag, ".out_valid"},     {63'd0, bus.out_valid}, {63'd0, ov});
    check({tag, ".retired_count"}, bus.retired_count,      cnt);
    check({tag, ".busy"},          {63'd0, bus.busy},      {63'd0, busy});
    check({tag, ".halt"},          {63'd0, bus.halt},      {63'd0, halt});
    check({tag, ".timeout"},       {63'd0, bus.timeout},   {63'd0, tmo});
  endtask

  task automatic check_head(input string tag, input logic [31:0] inst, input logic [63:0] dnpc);
    check({tag, ".out_inst"}, {32'd0, bus.out_inst}, {32'd0, inst});
    check({tag, ".out_dnpc"}, bus.out_dnpc, dnpc);
  endtask

  // One reset edge; returns in cycle 0 with reset released.
  task automatic do_reset();
    drive(1'b0, 32'd0, 64'd0, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 1'b0);

    // Basic trace (rows 0-2) then backpressure with 5 pushes into 4 entries.
    vecs[0]  = mk(1'b1, 32'h0000_0013, 64'h8000_0004, 1'b1,
                  1'b1, 1'b0, 32'h0, 64'h0, 64'd0, 1'b0);
    vecs[1]  = mk(1'b0, 32'h0, 64'h0, 1'b1,
                  1'b1, 1'b1, 32'h0000_0013, 64'h8000_0004, 64'd0, 1'b1);
    vecs[2]  = mk(1'b0, 32'h0, 64'h0, 1'b1,
                  1'b1, 1'b0, 32'h0, 64'h0, 64'd1, 1'b0);
    vecs[3]  = mk(1'b1, 32'h0000_00A0, 64'h8000_1000, 1'b0,
                  1'b1, 1'b0, 32'h0, 64'h0, 64'd1, 1'b0);
    vecs[4]  = mk(1'b1, 32'h0000_00A1, 64'h8000_1004, 1'b0,
                  1'b1, 1'b1, 32'h0000_00A0, 64'h8000_1000, 64'd1, 1'b1);
    vecs[5]  = mk(1'b1, 32'h0000_00A2, 64'h8000_1008, 1'b0,
                  1'b1, 1'b1, 32'h0000_00A0, 64'h8000_1000, 64'd1, 1'b1);
    vecs[6]  = mk(1'b1, 32'h0000_00A3, 64'h8000_100C, 1'b0,
                  1'b1, 1'b1, 32'h0000_00A0, 64'h8000_1000, 64'd1, 1'b1);
    vecs[7]  = mk(1'b1, 32'h0000_00A4, 64'h8000_1010, 1'b0,
                  1'b0, 1'b1, 32'h0000_00A0, 64'h8000_1000, 64'd1, 1'b1);
    vecs[8]  = mk(1'b1, 32'h0000_00A4, 64'h8000_1010, 1'b1,
                  1'b0, 1'b1, 32'h0000_00A0, 64'h8000_1000, 64'd1, 1'b1);
    vecs[9]  = mk(1'b1, 32'h0000_00A4, 64'h8000_1010, 1'b1,
                  1'b1, 1'b1, 32'h0000_00A1, 64'h8000_1004, 64'd2, 1'b1);
    vecs[10] = mk(1'b0, 32'h0, 64'h0, 1'b1,
                  1'b1, 1'b1, 32'h0000_00A2, 64'h8000_1008, 64'd3, 1'b1);
    vecs[11] = mk(1'b0, 32'h0, 64'h0, 1'b1,
                  1'b1, 1'b1, 32'h0000_00A3, 64'h8000_100C, 64'd4, 1'b1);
    vecs[12] = mk(1'b0, 32'h0, 64'h0, 1'b1,
                  1'b1, 1'b1, 32'h0000_00A4, 64'h8000_1010, 64'd5, 1'b1);
    vecs[13] = mk(1'b0, 32'h0, 64'h0, 1'b0,
                  1'b1, 1'b0, 32'h0, 64'h0, 64'd6, 1'b0);

    @(posedge clock);
    #1;
    do_reset();
    check_status("reset", 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].vld, vecs[i].inst, vecs[i].dnpc, vecs[i].ten);
      check_status($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].ov, vecs[i].cnt,
                   vecs[i].busy, vecs[i].halt, vecs[i].tmo);
      if (vecs[i].ov) check_head($sformatf("vec%0d", i), vecs[i].oinst, vecs[i].odnpc);
      tick();
    end

    // Wrap-around: 10 pushes with trace_en held high; each entry shows one cycle later.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      logic [31:0] ii;
      logic [63:0] dd;
      ii = 32'h0000_0200 + 32'(k);
      dd = 64'h9000_0000 + 64'(4 * k);
      drive(k < 10, ii, dd, 1'b1);
      check({"wrap.in_ready", $sformatf("%0d", k)}, {63'd0, bus.in_ready}, 64'd1);
      check({"wrap.out_valid", $sformatf("%0d", k)}, {63'd0, bus.out_valid},
            {63'd0, (k >= 1) && (k <= 10)});
      if ((k >= 1) && (k <= 10)) begin
        check_head($sformatf("wrap%0d", k), ii - 32'd1, dd - 64'd4);
      end
      tick();
    end
    check_status("wrap.end", 1'b1, 1'b0, 64'd10, 1'b0, 1'b0, 1'b0);

    // Reset mid-drain: buffer 3 entries, then reset discards them and the count.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h0000_0400 + 32'(k), 64'h0, 1'b0);
      tick();
    end
    check_status("middrain.pre", 1'b1, 1'b1, 64'd10, 1'b1, 1'b0, 1'b0);
    do_reset();
    check_status("middrain.post", 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

    // Halt: two entries then ebreak with trace_en low, then drain.
    drive(1'b1, 32'h0000_0300, 64'h8000_2004, 1'b0); tick();
    drive(1'b1, 32'h0000_0301, 64'h8000_2008, 1'b0); tick();
    drive(1'b1, Ebreak,        64'h8000_200C, 1'b0); tick();
    drive(1'b1, 32'h0000_0555, 64'h0, 1'b0);
    check_status("halt.held", 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0555, 64'h0, 1'b1);
    check_head("halt.pop0", 32'h0000_0300, 64'h8000_2004); tick();
    check_head("halt.pop1", 32'h0000_0301, 64'h8000_2008);
    check_status("halt.pop1", 1'b0, 1'b1, 64'd1, 1'b1, 1'b0, 1'b0); tick();
    check_head("halt.pop2", Ebreak, 64'h8000_200C);
    check_status("halt.pop2", 1'b0, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0); tick();
    check_status("halt.done", 1'b0, 1'b0, 64'd3, 1'b0, 1'b1, 1'b0); tick();
    check_status("halt.sticky", 1'b0, 1'b0, 64'd3, 1'b0, 1'b1, 1'b0);

    // Ebreak into an empty FIFO with trace_en high: halt two cycles after accept.
    do_reset();
    drive(1'b1, Ebreak, 64'h8000_3000, 1'b1); tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1);
    check_status("ebr.c1", 1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0); tick();
    check_status("ebr.c2", 1'b0, 1'b0, 64'd1, 1'b0, 1'b1, 1'b0);

    // Timeout: idle from reset, cycles 0..15 clear, cycle 16 stuck.
    do_reset();
    for (int c = 0; c <= 17; c++) begin
      check({"tmo.timeout", $sformatf("%0d", c)}, {63'd0, bus.timeout}, {63'd0, c >= 16});
      check({"tmo.in_ready", $sformatf("%0d", c)}, {63'd0, bus.in_ready}, {63'd0, c < 16});
      tick();
    end

    // Timeout restart: one accept at cycle 10 moves expiry to cycle 27.
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      drive(c == 10, 32'h0000_0600, 64'h8000_4000, 1'b1);
      if ((c == 16) || (c == 26) || (c == 27)) begin
        check({"tmo2.timeout", $sformatf("%0d", c)}, {63'd0, bus.timeout}, {63'd0, c == 27});
      end
      tick();
    end
    check_status("tmo2.end", 1'b0, 1'b0, 64'd1, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
